// File: rtl/serial_bram_slave_if.sv
// serial_bram_slave_if: serial frame bus plus bram port between master, slave front end and bram
interface serial_bram_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) ();
  logic                  rx;
  logic                  rx_valid;
  logic                  ready;
  logic                  tx;
  logic                  tx_valid;
  logic                  done;
  logic                  bram_wr;
  logic [ADDR_WIDTH-1:0] bram_address;
  logic [DATA_WIDTH-1:0] bram_data;
  logic [DATA_WIDTH-1:0] bram_q;
  modport slave (
    input  rx, rx_valid, bram_q,
    output ready, tx, tx_valid, done, bram_wr, bram_address, bram_data
  );
  modport master (
    output rx, rx_valid, bram_q,
    input  ready, tx, tx_valid, done, bram_wr, bram_address, bram_data
  );
endinterface

// File: rtl/serial_bram_slave.sv
// serial_bram_slave: deserialises write/read frames into bram accesses and serialises read data back
module serial_bram_slave #(
  parameter int MEMORY_DEPTH = 4096,
  parameter int DATA_WIDTH   = 16
) (
  input logic                clk,
  input logic                rstN,
  serial_bram_slave_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(MEMORY_DEPTH);
  localparam int CW = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] D_PEN  = CW'(DATA_WIDTH - 2);
  typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, WRITE, READ_WAIT, READ_LATCH, TX_DATA} state_t;
  state_t                state;
  logic                  ctrl;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic [DATA_WIDTH-1:0] tx_sr;
  assign bus.ready = state == IDLE;
  // frame sequencer: receive fields, issue the bram access, then stream read data out MSB first
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state            <= IDLE;
      ctrl             <= 1'b0;
      cnt              <= '0;
      addr_sr          <= '0;
      data_sr          <= '0;
      tx_sr            <= '0;
      bus.bram_wr      <= 1'b0;
      bus.bram_address <= '0;
      bus.bram_data    <= '0;
      bus.tx           <= 1'b0;
      bus.tx_valid     <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.rx_valid) begin
          ctrl  <= bus.rx;
          cnt   <= '0;
          state <= RX_ADDR;
        end
        RX_ADDR: if (!bus.rx_valid) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          addr_sr <= {addr_sr[ADDR_WIDTH-2:0], bus.rx};
          if (cnt == A_LAST) begin
            cnt <= '0;
            if (ctrl) state <= RX_DATA;
            else begin
              state            <= READ_WAIT;
              bus.bram_address <= {addr_sr[ADDR_WIDTH-2:0], bus.rx};
            end
          end else cnt <= cnt + 1'b1;
        end
        RX_DATA: if (!bus.rx_valid) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          data_sr <= {data_sr[DATA_WIDTH-2:0], bus.rx};
          if (cnt == D_LAST) begin
            cnt              <= '0;
            state            <= WRITE;
            bus.bram_wr      <= 1'b1;
            bus.bram_address <= addr_sr;
            bus.bram_data    <= {data_sr[DATA_WIDTH-2:0], bus.rx};
            bus.done         <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        WRITE: begin
          bus.bram_wr <= 1'b0;
          bus.done    <= 1'b0;
          state       <= IDLE;
        end
        READ_WAIT: state <= READ_LATCH;
        READ_LATCH: begin
          tx_sr        <= {bus.bram_q[DATA_WIDTH-2:0], 1'b0};
          bus.tx       <= bus.bram_q[DATA_WIDTH-1];
          bus.tx_valid <= 1'b1;
          cnt          <= '0;
          state        <= TX_DATA;
        end
        TX_DATA: if (cnt == D_LAST) begin
          bus.tx       <= 1'b0;
          bus.tx_valid <= 1'b0;
          bus.done     <= 1'b0;
          cnt          <= '0;
          state        <= IDLE;
        end else begin
          bus.tx   <= tx_sr[DATA_WIDTH-1];
          tx_sr    <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
          bus.done <= cnt == D_PEN;
          cnt      <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_bram_slave.sv
// tb_serial_bram_slave: directed and random frames checked against a word-level memory model
module tb_serial_bram_slave;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] mem [4096];
  logic [15:0] ref_mem [int];
  int written [$];

  always #5 clk = ~clk;

  serial_bram_slave_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();
  serial_bram_slave #(.MEMORY_DEPTH(4096), .DATA_WIDTH(16)) dut (.clk(clk), .rstN(rstN), .bus(bus));

  // bram with one-cycle registered read
  always @(posedge clk) begin
    if (bus.bram_wr) mem[bus.bram_address] <= bus.bram_data;
    bus.bram_q <= mem[bus.bram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [11:0] a, input logic [15:0] d, input bit poke);
    logic [28:0] f;
    f = {1'b1, a, d};
    chk("wr_ready", bus.ready, 1);
    for (int i = 28; i >= 0; i--) begin
      bus.rx_valid = 1'b1;
      bus.rx = f[i];
      tick();
    end
    bus.rx_valid = poke;
    bus.rx = poke;
    chk("wr_en", bus.bram_wr, 1);
    chk("wr_addr", bus.bram_address, a);
    chk("wr_data", bus.bram_data, d);
    chk("wr_done", bus.done, 1);
    chk("wr_busy", bus.ready, 0);
    tick();
    bus.rx_valid = 1'b0;
    bus.rx = 1'b0;
    chk("wr_en_off", bus.bram_wr, 0);
    chk("wr_done_off", bus.done, 0);
    chk("wr_ready_again", bus.ready, 1);
    if (poke) begin
      tick();
      chk("poke_ignored", bus.ready, 1);
    end
    ref_mem[a] = d;
  endtask

  task automatic read_frame(input logic [11:0] a, input int rst_bit);
    logic [12:0] f;
    logic [15:0] word;
    f = {1'b0, a};
    word = '0;
    chk("rd_ready", bus.ready, 1);
    for (int i = 12; i >= 0; i--) begin
      bus.rx_valid = 1'b1;
      bus.rx = f[i];
      tick();
    end
    bus.rx_valid = 1'b0;
    bus.rx = 1'b0;
    chk("rd_addr", bus.bram_address, a);
    chk("rd_no_wr", bus.bram_wr, 0);
    chk("rd_wait_txv", bus.tx_valid, 0);
    tick();
    chk("rd_latch_txv", bus.tx_valid, 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("tx_valid", bus.tx_valid, 1);
      chk("tx_done", bus.done, 32'(i == 15));
      word = {word[14:0], bus.tx};
      if (i == rst_bit) begin
        rstN = 1'b0;
        #1;
        chk("rst_txv", bus.tx_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready", bus.ready, 1);
        #3;
        rstN = 1'b1;
        return;
      end
      tick();
    end
    chk("tx_word", word, ref_mem[int'(a)]);
    chk("tx_end_valid", bus.tx_valid, 0);
    chk("tx_end_ready", bus.ready, 1);
  endtask

  initial begin
    logic [11:0] ra;
    logic [15:0] rd;
    foreach (mem[i]) mem[i] = 16'($urandom);
    bus.rx = 1'b0;
    bus.rx_valid = 1'b0;
    #3;
    chk("rst_ready0", bus.ready, 1);
    chk("rst_wr0", bus.bram_wr, 0);
    chk("rst_addr0", bus.bram_address, 0);
    chk("rst_data0", bus.bram_data, 0);
    chk("rst_tx0", bus.tx, 0);
    chk("rst_txv0", bus.tx_valid, 0);
    chk("rst_done0", bus.done, 0);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    write_frame(12'h005, 16'h1234, 1'b0);
    read_frame(12'h005, -1);
    write_frame(12'hFFF, 16'hFFFF, 1'b1);
    read_frame(12'hFFF, -1);
    for (int i = 28; i >= 22; i--) begin
      bus.rx_valid = 1'b1;
      bus.rx = 1'b1;
      tick();
      chk("abort_wr", bus.bram_wr, 0);
    end
    bus.rx_valid = 1'b0;
    tick();
    chk("abort_ready", bus.ready, 1);
    chk("abort_done", bus.done, 0);
    chk("abort_wr_end", bus.bram_wr, 0);
    tick();
    chk("abort_idle", bus.ready, 1);
    write_frame(12'h001, 16'd5, 1'b0);
    write_frame(12'h002, 16'd10, 1'b0);
    write_frame(12'h003, 16'd12, 1'b0);
    read_frame(12'h001, -1);
    read_frame(12'h002, -1);
    read_frame(12'h003, -1);
    read_frame(12'h005, 4);
    tick();
    chk("post_rst_ready", bus.ready, 1);
    read_frame(12'h005, -1);
    written = {12'h005, 12'hFFF, 12'h001, 12'h002, 12'h003};
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        ra = 12'($urandom_range(0, 4095));
        rd = 16'($urandom);
        write_frame(ra, rd, 1'b0);
        written.push_back(int'(ra));
      end else begin
        read_frame(12'(written[$urandom_range(0, written.size() - 1)]), -1);
      end
    end
    read_frame(12'(written[written.size() - 1]), -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
